// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the M stage: IDLE -> WAIT -> DONE handshake with pipeline stall.
// Optional wait-state abort is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memreqM,
  input  logic                we_memM,
  input  logic [DATA_W/8-1:0] be_memM,
  input  logic [ADDR_W-1:0]   addrM,
  input  logic [DATA_W-1:0]   srcbM,
  input  logic                flashM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                stall,
  output logic [DATA_W-1:0]   rdataW,
  output logic                rdata_vld,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType state;
  logic     flushed;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  logic [CntW-1:0] cnt;
`endif

  // Hold the pipeline while a request is being accepted or is in flight; DONE releases it.
  assign stall = ((state == IDLE) && memreqM && !flashM) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flushed    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdataW     <= '0;
      rdata_vld  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err        <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      rdata_vld <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (memreqM && !flashM) begin
            state      <= WAIT;
            flushed    <= 1'b0;
            dmem_req   <= 1'b1;
            dmem_we    <= we_memM;
            dmem_be    <= be_memM;
            dmem_addr  <= addrM;
            dmem_wdata <= srcbM;
`ifdef MEM_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        WAIT: begin
          // A flush cannot cancel a bus cycle already issued; it only suppresses the result.
          if (flashM) begin
            flushed <= 1'b1;
          end
          if (dmem_ack) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            if (!dmem_we) begin
              rdataW <= dmem_rdata;
            end
            rdata_vld <= !dmem_we && !flushed && !flashM;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CntLast) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + CntW'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; follows MEM_TIMEOUT_EN for the timeout scenario.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        memreqM;
  logic        we_memM;
  logic [3:0]  be_memM;
  logic [31:0] addrM;
  logic [31:0] srcbM;
  logic        flashM;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] rdataW;
  logic        rdata_vld;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  mem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memreqM(memreqM),
    .we_memM(we_memM),
    .be_memM(be_memM),
    .addrM(addrM),
    .srcbM(srcbM),
    .flashM(flashM),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_be(dmem_be),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .stall(stall),
    .rdataW(rdataW),
    .rdata_vld(rdata_vld),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] srcb, input logic flash);
    memreqM = req;
    we_memM = we;
    be_memM = be;
    addrM   = addr;
    srcbM   = srcb;
    flashM  = flash;
  endtask

  // Called at a negedge in IDLE with the request applied; returns sitting in the DONE cycle.
  task automatic runAccess(input int ackOnWait, input logic [31:0] rdata, input int flashOnWait,
                           output int reqCyc, output int stallCyc);
    int waitIdx;
    waitIdx  = 0;
    reqCyc   = 0;
    stallCyc = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (stall) stallCyc++;
      if (dmem_req) begin
        reqCyc++;
        waitIdx++;
        if (waitIdx == flashOnWait) flashM = 1'b1;
        if (waitIdx == ackOnWait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end else if (c > 0) begin
        break;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    int reqCyc;
    int stallCyc;
    int errSeen;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Reset with ack toggling
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checkOutput("rst_req", dmem_req, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_rdataW", rdataW, 32'h0);
    checkOutput("rst_vld", rdata_vld, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_addr", dmem_addr, 32'h0);
    checkOutput("rst_wdata", dmem_wdata, 32'h0);
    rst = 1'b0;

    // Load, ack on 3rd WAIT cycle
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
    runAccess(3, 32'hDEADBEEF, 0, reqCyc, stallCyc);
    checkOutput("ld_reqCycles", reqCyc, 3);
    checkOutput("ld_stallCycles", stallCyc, 4);
    checkOutput("ld_rdataW", rdataW, 32'hDEADBEEF);
    checkOutput("ld_vld", rdata_vld, 1'b1);
    checkOutput("ld_doneStall", stall, 1'b0);
    checkOutput("ld_addr", dmem_addr, 32'h100);
    checkOutput("ld_be", dmem_be, 4'hF);
    checkOutput("ld_we", dmem_we, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("ld_vldPulse", rdata_vld, 1'b0);
    checkOutput("ld_rdataHold", rdataW, 32'hDEADBEEF);

    // Store, ack on 1st WAIT cycle
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b0010, 32'h203, 32'h0000AB00, 1'b0);
    runAccess(1, 32'h12345678, 0, reqCyc, stallCyc);
    checkOutput("st_reqCycles", reqCyc, 1);
    checkOutput("st_stallCycles", stallCyc, 2);
    checkOutput("st_vld", rdata_vld, 1'b0);
    checkOutput("st_we", dmem_we, 1'b1);
    checkOutput("st_be", dmem_be, 4'b0010);
    checkOutput("st_wdata", dmem_wdata, 32'h0000AB00);
    checkOutput("st_addr", dmem_addr, 32'h203);
    checkOutput("st_rdataHold", rdataW, 32'hDEADBEEF);

    // Load flushed during WAIT, ack two cycles later
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0);
    runAccess(3, 32'hCAFEF00D, 1, reqCyc, stallCyc);
    checkOutput("fl_reqCycles", reqCyc, 3);
    checkOutput("fl_vld", rdata_vld, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b1);
    #1;
    checkOutput("fl_idleStall", stall, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("fl_idleNoReq", dmem_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Back-to-back loads with immediate ack
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0);
    runAccess(1, 32'h11111111, 0, reqCyc, stallCyc);
    checkOutput("b2b_vld1", rdata_vld, 1'b1);
    checkOutput("b2b_rdata1", rdataW, 32'h11111111);
    addrM = 32'h404;
    @(negedge clk);
    #1;
    checkOutput("b2b_idleReq", dmem_req, 1'b0);
    checkOutput("b2b_idleStall", stall, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("b2b_req2", dmem_req, 1'b1);
    checkOutput("b2b_addr2", dmem_addr, 32'h404);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h22222222;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checkOutput("b2b_vld2", rdata_vld, 1'b1);
    checkOutput("b2b_rdata2", rdataW, 32'h22222222);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Stray ack in IDLE is ignored
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h33333333;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checkOutput("idleAck_req", dmem_req, 1'b0);
    checkOutput("idleAck_vld", rdata_vld, 1'b0);
    checkOutput("idleAck_rdata", rdataW, 32'h22222222);

    // Load that is never acknowledged
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b0);
`ifdef MEM_TIMEOUT_EN
    reqCyc  = 0;
    errSeen = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (dmem_req) reqCyc++;
      else break;
    end
    checkOutput("to_reqCycles", reqCyc, 4);
    checkOutput("to_err", err, 1'b1);
    checkOutput("to_vld", rdata_vld, 1'b0);
    checkOutput("to_doneStall", stall, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("to_errPulse", err, 1'b0);
`else
    reqCyc  = 0;
    errSeen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (dmem_req) reqCyc++;
      if (err) errSeen++;
    end
    checkOutput("noTo_reqCycles", reqCyc, 100);
    checkOutput("noTo_errSeen", errSeen, 0);
    checkOutput("noTo_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("noTo_rstReq", dmem_req, 1'b0);
`endif

    // Reset during WAIT discards the access
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rstW_reqBefore", dmem_req, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h44444444;
    @(negedge clk);
    rst      = 1'b0;
    dmem_ack = 1'b0;
    #1;
    checkOutput("rstW_req", dmem_req, 1'b0);
    checkOutput("rstW_stall", stall, 1'b0);
    checkOutput("rstW_rdataW", rdataW, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rstW_vld", rdata_vld, 1'b0);
    checkOutput("rstW_err", err, 1'b0);
    checkOutput("rstW_reqStays", dmem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
